// File: rtl/seq_pkg.sv
// Shared types and constants for the note sequencer: FSM states, pattern geometry,
// byte layout of one step and a helper that splits a stored step word into fields.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    localparam int STEPS          = 64;
    localparam int STEP_W         = $clog2(STEPS);
    localparam int BYTES_PER_STEP = 4;

    localparam logic [1:0] FREQ_HI = 2'd0;
    localparam logic [1:0] FREQ_LO = 2'd1;
    localparam logic [1:0] DUR     = 2'd2;
    localparam logic [1:0] GATE    = 2'd3;

    typedef struct packed {
        logic [15:0] freq;
        logic [7:0]  dur;
        logic [7:0]  gate_len;
    } step_t;

    // Byte n of a step lives in bits [8n+7:8n] of the stored word.
    function automatic logic [7:0] step_byte(input logic [31:0] word, input logic [1:0] off);
        return word[{off, 3'b000} +: 8];
    endfunction

    function automatic step_t unpack_step(input logic [31:0] word);
        step_t s;
        s.freq     = {step_byte(word, FREQ_HI), step_byte(word, FREQ_LO)};
        s.dur      = step_byte(word, DUR);
        s.gate_len = step_byte(word, GATE);
        return s;
    endfunction

endpackage

// File: rtl/seq_step_ram.sv
// Pattern store: STEPS x 32-bit words split into four independent byte lanes, each with
// its own write enable and a registered read-first output. Contents are never reset.
module seq_step_ram
    import seq_pkg::*;
(
    input  logic                          clk_i,
    input  logic [BYTES_PER_STEP-1:0]     we_i,
    input  logic [STEP_W-1:0]             waddr_i,
    input  logic [8*BYTES_PER_STEP-1:0]   wdata_i,
    input  logic                          re_i,
    input  logic [STEP_W-1:0]             raddr_i,
    output logic [8*BYTES_PER_STEP-1:0]   rdata_o
);

    logic [8*BYTES_PER_STEP-1:0] rdata_q;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_STEP; gi++) begin : g_lane
            logic [7:0] lane_q [STEPS];

            // Read and write in the same block: a same-address read returns the old byte.
            always_ff @(posedge clk_i) begin
                if (we_i[gi]) begin
                    lane_q[waddr_i] <= wdata_i[8*gi +: 8];
                end
                if (re_i) begin
                    rdata_q[8*gi +: 8] <= lane_q[raddr_i];
                end
            end
        end
    endgenerate

    assign rdata_o = rdata_q;

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: plays a downloaded 64-step pattern as (frequency, gate) on one voice,
// advancing on a divided tick; play high runs the pattern, play low returns to IDLE.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int TICK_DIV  = 24000,
    parameter int IOCTL_IDX = 3,
    parameter int LOOP      = 1
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        play,
    output logic [15:0] tone_freq,
    output logic        gate,
    output logic [5:0]  step_idx,
    output logic        busy
);

    localparam int                DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [7:0]        IDX8     = IOCTL_IDX[7:0];

    seq_state_e          state_q, state_d;
    logic                play_q, rise_q;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick;
    logic [7:0]          tick_cnt_q, tick_cnt_d, tick_nxt;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [15:0]         freq_q, freq_d;
    logic                gate_q, gate_d;
    logic [7:0]          dur_q, dur_d;
    logic [7:0]          gate_len_q, gate_len_d;

    logic                      wr_hit;
    logic [BYTES_PER_STEP-1:0] wr_be;
    logic                      rd_en;
    logic [31:0]               rd_word;
    step_t                     rd_step;

    // Download port: only the low 256 bytes of the selected index map onto the pattern.
    assign wr_hit = ioctl_wr && (ioctl_index == IDX8) && (ioctl_addr[24:8] == 17'd0);
    assign wr_be  = wr_hit ? (4'b0001 << ioctl_addr[1:0]) : 4'b0000;

    seq_step_ram u_ram (
        .clk_i   (CLK),
        .we_i    (wr_be),
        .waddr_i (ioctl_addr[7:2]),
        .wdata_i ({BYTES_PER_STEP{ioctl_dout}}),
        .re_i    (rd_en),
        .raddr_i (step_q),
        .rdata_o (rd_word)
    );

    assign rd_step  = unpack_step(rd_word);
    assign tick     = (div_q == DIV_LAST);
    assign tick_nxt = tick_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        freq_d     = freq_q;
        gate_d     = gate_q;
        tick_cnt_d = tick_cnt_q;
        dur_d      = dur_q;
        gate_len_d = gate_len_q;
        rd_en      = 1'b0;

        if (state_q != ST_IDLE && !play) begin
            state_d = ST_IDLE;
            gate_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_q) begin
                        step_d  = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    rd_en   = 1'b1;
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (rd_step.dur == 8'd0) begin
                        if (LOOP != 0) begin
                            step_d  = '0;
                            state_d = ST_FETCH;
                        end else begin
                            gate_d  = 1'b0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        freq_d     = rd_step.freq;
                        dur_d      = rd_step.dur;
                        gate_len_d = rd_step.gate_len;
                        tick_cnt_d = 8'd0;
                        gate_d     = (rd_step.gate_len != 8'd0);
                        state_d    = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        tick_cnt_d = tick_nxt;
                        if (tick_nxt == gate_len_q) begin
                            gate_d = 1'b0;
                        end
                        // Gate is left alone at step end, so gate_len >= dur carries into the next step.
                        if (tick_nxt == dur_q) begin
                            step_d  = step_q + STEP_W'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    gate_d  = 1'b0;
                end
            endcase
        end
    end

    // Tick phase restarts when a run starts so the first step has a full tick period.
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if ((state_q == ST_IDLE || state_q == ST_DONE) && state_d == ST_FETCH) begin
            div_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            play_q     <= 1'b0;
            rise_q     <= 1'b0;
            div_q      <= '0;
            tick_cnt_q <= 8'd0;
            step_q     <= '0;
            freq_q     <= 16'd0;
            gate_q     <= 1'b0;
            dur_q      <= 8'd0;
            gate_len_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            play_q     <= play;
            rise_q     <= play && !play_q;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            step_q     <= step_d;
            freq_q     <= freq_d;
            gate_q     <= gate_d;
            dur_q      <= dur_d;
            gate_len_q <= gate_len_d;
        end
    end

    assign tone_freq = freq_q;
    assign gate      = gate_q;
    assign step_idx  = step_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_PLAY);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a looping and a one-shot instance share all inputs and are
// compared every cycle against a countdown-based reference model plus directed checks.
module tb_note_sequencer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        play = 1'b0;

    logic [15:0] tf0, tf1;
    logic        g0, g1, b0, b1;
    logic [5:0]  si0, si1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    note_sequencer #(.TICK_DIV(TD), .IOCTL_IDX(3), .LOOP(1)) u_loop (
        .CLK(clk), .rst_n(rst_n), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .play(play),
        .tone_freq(tf0), .gate(g0), .step_idx(si0), .busy(b0)
    );

    note_sequencer #(.TICK_DIV(TD), .IOCTL_IDX(3), .LOOP(0)) u_once (
        .CLK(clk), .rst_n(rst_n), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .play(play),
        .tone_freq(tf1), .gate(g1), .step_idx(si1), .busy(b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. Index 0 mirrors u_loop, 1 mirrors u_once.
    // ph: 0 stopped, 1 reading step, 2 step data arriving, 3 sounding, 4 finished.
    int pat [256];
    int ph [2], stp [2], frq [2], rem [2], gleft [2], base [2];
    int ld [2][4];
    bit gt [2], pq [2], rq [2];
    int n = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; stp[k] = 0; frq[k] = 0; gt[k] = 0;
            pq[k] = 0; rq[k] = 0; rem[k] = 0; gleft[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        bit tick_now, start;
        tick_now = ((n - base[k]) % TD) == 0;
        start    = rq[k];
        rq[k]    = play && !pq[k];
        pq[k]    = play;
        if (ph[k] != 0 && !play) begin
            ph[k] = 0;
            gt[k] = 0;
        end else begin
            case (ph[k])
                0: if (start) begin stp[k] = 0; ph[k] = 1; base[k] = n; end
                1: begin
                    for (int b = 0; b < 4; b++) ld[k][b] = pat[stp[k]*4 + b];
                    ph[k] = 2;
                end
                2: begin
                    if (ld[k][2] == 0) begin
                        if (k == 0) begin stp[k] = 0; ph[k] = 1; end
                        else begin ph[k] = 4; gt[k] = 0; end
                    end else begin
                        frq[k]   = ld[k][0] * 256 + ld[k][1];
                        gt[k]    = (ld[k][3] != 0);
                        rem[k]   = ld[k][2];
                        gleft[k] = ld[k][3];
                        ph[k]    = 3;
                    end
                end
                3: if (tick_now) begin
                    rem[k]--;
                    if (gleft[k] > 0) begin
                        gleft[k]--;
                        if (gleft[k] == 0) gt[k] = 0;
                    end
                    if (rem[k] == 0) begin stp[k] = (stp[k] + 1) % 64; ph[k] = 1; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_clock();
        n++;
        for (int k = 0; k < 2; k++) model_edge(k);
        if (ioctl_wr && ioctl_index == 8'd3 && ioctl_addr < 25'd256) pat[ioctl_addr] = ioctl_dout;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_clock();
    end

    always @(negedge clk) begin
        check("loop.freq", tf0, frq[0]);
        check("loop.gate", g0, gt[0]);
        check("loop.step", si0, stp[0]);
        check("loop.busy", b0, (ph[0] >= 1 && ph[0] <= 3));
        check("once.freq", tf1, frq[1]);
        check("once.gate", g1, gt[1]);
        check("once.step", si1, stp[1]);
        check("once.busy", b1, (ph[1] >= 1 && ph[1] <= 3));
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input int addr, input int d);
        ioctl_wr = 1'b1; ioctl_index = idx[7:0]; ioctl_addr = addr[24:0]; ioctl_dout = d[7:0];
        cyc(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic wr_step(input int s, input int f, input int dur, input int gl);
        wr(3, s*4 + 0, (f >> 8) & 255);
        wr(3, s*4 + 1, f & 255);
        wr(3, s*4 + 2, dur);
        wr(3, s*4 + 3, gl);
    endtask

    initial begin
        int w0, w1, p0, p1;
        bit found;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst.freq", tf0, 16'd0);
        check("rst.gate", g0, 1'b0);
        check("rst.step", si0, 6'd0);
        check("rst.busy", b0, 1'b0);

        $display("txn: fill 64 steps dur=1 gate=1, free run");
        for (int s = 0; s < 64; s++) wr_step(s, ($urandom_range(0, 255) << 8) | s, 1, 1);
        play = 1'b1;
        w0 = 0; w1 = 0;
        for (int i = 0; i < 400; i++) begin
            p0 = si0; p1 = si1;
            cyc(1);
            if (p0 == 63 && si0 == 0) w0++;
            if (p1 == 63 && si1 == 0) w1++;
        end
        check("wrap.loop", (w0 > 0), 1'b1);
        check("wrap.once", (w1 > 0), 1'b1);
        play = 1'b0;
        cyc(3);

        $display("txn: basic pattern, latency and loop");
        wr_step(0, 16'h1125, 3, 2);
        wr_step(1, 16'h0BAD, 0, 0);
        play = 1'b1;
        cyc(3);
        check("lat.pre", g0, 1'b0);
        cyc(1);
        check("lat.gate", g0, 1'b1);
        check("lat.freq", tf0, 16'h1125);
        check("lat.gate1", g1, 1'b1);
        cyc(5);
        check("gl.hold", g0, 1'b1);
        cyc(1);
        check("gl.off", g0, 1'b0);
        cyc(4);
        check("dur.next", si0, 6'd1);
        cyc(2);
        check("loop.back", si0, 6'd0);
        check("done.step", si1, 6'd1);
        check("done.busy", b1, 1'b0);
        check("done.gate", g1, 1'b0);
        cyc(2);
        check("loop.regate", g0, 1'b1);

        $display("txn: one-shot restart by play toggle");
        play = 1'b0;
        cyc(2);
        play = 1'b1;
        cyc(4);
        check("restart.gate", g1, 1'b1);
        check("restart.step", si1, 6'd0);

        $display("txn: play drop and async reset mid-play");
        cyc(3);
        play = 1'b0;
        cyc(1);
        check("drop.gate", g0, 1'b0);
        check("drop.busy", b0, 1'b0);
        check("drop.freq", tf0, 16'h1125);
        play = 1'b1;
        cyc(6);
        rst_n = 1'b0;
        #1;
        check("arst.gate", g0, 1'b0);
        check("arst.freq", tf0, 16'd0);
        check("arst.step", si0, 6'd0);
        check("arst.busy", b0, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        check("ram.kept.gate", g0, 1'b1);
        check("ram.kept.freq", tf0, 16'h1125);

        $display("txn: legato and zero gate length");
        play = 1'b0;
        cyc(2);
        wr_step(0, 16'h2222, 3, 5);
        wr_step(1, 16'h3333, 2, 0);
        wr_step(2, 16'h4444, 2, 2);
        wr_step(3, 16'h0000, 0, 0);
        play = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc(1);
            if (si0 == 6'd1) found = 1;
        end
        check("wait.legato", found, 1'b1);
        check("legato.gate", g0, 1'b1);
        cyc(2);
        check("gl0.gate", g0, 1'b0);
        check("gl0.freq", tf0, 16'h3333);

        $display("txn: live write and ignored writes");
        play = 1'b0;
        cyc(2);
        wr_step(0, 16'h1111, 6, 3);
        wr_step(1, 16'h2222, 2, 2);
        wr_step(2, 16'h0000, 0, 0);
        play = 1'b1;
        cyc(8);
        wr(3, 4, 8'h7E);
        wr(3, 5, 8'h55);
        wr(2, 4, 8'hAA);
        wr(3, 25'h104, 8'hBB);
        wr(2, 5, 8'hCC);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc(1);
            if (si0 == 6'd1) found = 1;
        end
        check("wait.step1", found, 1'b1);
        cyc(2);
        check("live.freq", tf0, 16'h7E55);

        for (int it = 0; it < 12; it++) begin
            $display("txn: random pattern %0d", it);
            play = 1'b0;
            cyc(2);
            for (int s = 0; s < 8; s++)
                wr_step(s, $urandom_range(0, 65535),
                        ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3),
                        $urandom_range(0, 4));
            wr_step(8, 0, 0, 0);
            play = 1'b1;
            cyc($urandom_range(10, 40));
            for (int j = 0; j < 4; j++)
                wr($urandom_range(2, 3), $urandom_range(0, 511), $urandom_range(0, 255));
            cyc($urandom_range(10, 40));
        end

        play = 1'b0;
        cyc(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 24000: CLK cycles per sequencer tick (1 ms at 24 MHz).
REQ-002 SHALL have parameter IOCTL_IDX, default 3: ioctl_index value selecting the pattern download.
REQ-003 SHALL have parameter LOOP, default 1: 1 restarts at step 0 on end marker, 0 stops.
REQ-004 SHALL have ports: CLK  in  1  single system clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: ioctl_wr  in  1  byte write strobe; ioctl_index  in  8  download index; ioctl_addr  in  25  byte address; ioctl_dout  in  8  write data.
REQ-006 SHALL have port play  in  1  level; high runs the sequence, low stops it.
REQ-007 SHALL have ports: tone_freq  out  16  voice frequency word; gate  out  1  voice gate (high = note on).
REQ-008 SHALL have ports: step_idx  out  6  current step; busy  out  1  high outside IDLE/DONE.

Function
REQ-009 SHALL hold a 64-step pattern, 4 bytes per step: byte0 freq hi, byte1 freq lo, byte2 dur (ticks), byte3 gate_len (ticks).
REQ-010 SHALL write byte ioctl_addr[7:0] when ioctl_wr=1, ioctl_index==IOCTL_IDX and ioctl_addr[24:8]==0; other writes ignored.
REQ-011 SHALL accept writes in every state; a write and a read of the same step in one cycle returns old data (read-first).
REQ-012 SHALL generate a one-cycle tick every TICK_DIV cycles; tick counter clears on entry to FETCH from IDLE/DONE.
REQ-013 SHALL implement states IDLE, FETCH, LOAD, PLAY, DONE.
REQ-014 IDLE: on play rising edge (registered), step_idx<=0, go FETCH.
REQ-015 FETCH: issue synchronous read of step step_idx; next cycle LOAD.
REQ-016 LOAD: dur==0 -> LOOP=1: step_idx<=0, FETCH; LOOP=0: DONE, gate<=0. Else tone_freq<={b0,b1}, tick_cnt<=0, gate<=(gate_len!=0), PLAY.
REQ-017 PLAY: each tick increments tick_cnt (8 bits); when tick_cnt+1==gate_len, gate<=0; when tick_cnt+1==dur, step_idx<=step_idx+1 (63 wraps to 0), FETCH.
REQ-018 gate_len>=dur SHALL keep gate high into the next step (legato, no retrigger).
REQ-019 tone_freq SHALL hold its value through FETCH/LOAD and in IDLE/DONE.
REQ-020 play low in any state except IDLE SHALL force gate<=0 and IDLE next cycle; tone_freq retained.
REQ-021 DONE: stays until play falls (->IDLE); a new rising edge is required to restart.
REQ-022 Latency from play rising edge (at CLK edge) to gate high SHALL be 4 cycles (edge reg, IDLE, FETCH, LOAD).

Reset
REQ-023 rst_n low SHALL asynchronously set state IDLE, tone_freq 0, gate 0, step_idx 0, busy 0, tick counters 0, play edge register 0.
REQ-024 Pattern RAM contents SHALL NOT be reset; reset mid-playback SHALL drop gate immediately.

Structure
REQ-025 Shared package seq_pkg SHALL hold the state enum, STEPS=64, byte offsets (FREQ_HI=0, FREQ_LO=1, DUR=2, GATE=3).
REQ-026 Pattern storage SHALL be sub-module seq_step_ram: 64x32, per-byte write enable, synchronous read-first port, no reset.

Verification (TICK_DIV=4 for sim)
REQ-027 Load step0={0x11,0x25,3,2}, step1 dur=0; play=1 -> gate high 4 cycles after edge, tone_freq=0x1125, gate low after 2 ticks, FETCH after 3 ticks, loops to step 0 (LOOP=1).
REQ-028 LOOP=0, same pattern -> DONE after step 1, gate=0, busy=0; play toggle restarts at step 0.
REQ-029 All 64 steps dur=1, gate_len=1 -> step_idx 0..63 then wraps to 0, no end marker.
REQ-030 gate_len=5, dur=3 -> gate stays high across step boundary; gate_len=0 -> gate never rises.
REQ-031 play dropped mid-PLAY -> gate=0 and IDLE next cycle; rst_n pulse mid-PLAY -> all outputs 0 asynchronously, RAM retained.
REQ-032 Write to step1 freq during step0 PLAY -> new value used; write with ioctl_index=2 or addr=0x100 -> no change.
